// File: rtl/control_sequencer_if.sv
// Signal bundle between the control sequencer and the 16-bit datapath/memory.
// The sequencer side owns every load/select strobe and the memory request lines;
// the datapath side supplies the IR fields, the branch condition, run and mem_ready.
interface control_sequencer_if;
  logic       run;
  logic [3:0] ir_1;
  logic [1:0] ir_3;
  logic       cc;
  logic       mem_ready;

  logic       ldMAR;
  logic       ldIR;
  logic       Tlabel;
  logic       ALUon;
  logic [2:0] fnSelect;
  logic       mm;
  logic       ldFlag;
  logic       ldPC;
  logic       incPC;
  logic       ldReg;
  logic       mem_rd;
  logic       mem_wr;
  logic       halted;
  logic       err;
  logic [3:0] state;

  modport master (
    input  run, ir_1, ir_3, cc, mem_ready,
    output ldMAR, ldIR, Tlabel, ALUon, fnSelect, mm, ldFlag, ldPC, incPC,
           ldReg, mem_rd, mem_wr, halted, err, state
  );

  modport slave (
    output run, ir_1, ir_3, cc, mem_ready,
    input  ldMAR, ldIR, Tlabel, ALUon, fnSelect, mm, ldFlag, ldPC, incPC,
           ldReg, mem_rd, mem_wr, halted, err, state
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit datapath.
// Strobes are decoded from the registered state only (ldPC additionally follows cc in BR).
// Memory states F1/L1/S1 wait on mem_ready with a bounded counter; running out of
// patience traps the machine in ERR until reset. IR[9:8] (ir_3) is routed to the ALU
// by the datapath itself whenever ALUon is high, so the sequencer never inspects it.
// Debug state encoding: IDLE=0 F0=1 F1=2 F2=3 DEC=4 ALU=5 WB=6 BR=7 L0=8 L1=9
// L2=10 S0=11 S1=12 HALT=13 ERR=14.
module control_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input logic                  clk,
  input logic                  reset,
  control_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,  F0  = 4'd1,  F1   = 4'd2,  F2  = 4'd3,
    DEC  = 4'd4,  ALU = 4'd5,  WB   = 4'd6,  BR  = 4'd7,
    L0   = 4'd8,  L1  = 4'd9,  L2   = 4'd10, S0  = 4'd11,
    S1   = 4'd12, HALT = 4'd13, ERR = 4'd14
  } state_t;

  // The wait counter holds the number of no-ready cycles already spent in the
  // current memory state, so the last tolerated value is MEM_TIMEOUT-1.
  localparam logic [TW-1:0] LAST_WAIT = TW'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   waitCnt_q, waitCnt_d;
  logic            waitExpired;

  logic       ldMAR, ldIR, Tlabel, ALUon, mm, ldFlag, ldPC, incPC, ldReg;
  logic       memRd, memWr, halted, err;
  logic [2:0] fnSelect;

  assign waitExpired = (waitCnt_q == LAST_WAIT);

  // State and wait counter registers; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Next-state selection and Moore strobe decode for the current state.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = '0;
    ldMAR     = 1'b0;
    ldIR      = 1'b0;
    Tlabel    = 1'b0;
    ALUon     = 1'b0;
    fnSelect  = 3'b000;
    mm        = 1'b0;
    ldFlag    = 1'b0;
    ldPC      = 1'b0;
    incPC     = 1'b0;
    ldReg     = 1'b0;
    memRd     = 1'b0;
    memWr     = 1'b0;
    halted    = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: if (bus.run) state_d = F0;
      F0: begin
        ldMAR   = 1'b1;
        state_d = F1;
      end
      F1: begin
        memRd = 1'b1;
        if (bus.mem_ready)  state_d = F2;
        else if (waitExpired) state_d = ERR;
        else waitCnt_d = waitCnt_q + 1'b1;
      end
      F2: begin
        ldIR    = 1'b1;
        incPC   = 1'b1;
        state_d = DEC;
      end
      DEC: begin
        case (bus.ir_1)
          4'b0000: state_d = ALU;
          4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
          4'b0110, 4'b0111, 4'b1000, 4'b1001: state_d = BR;
          4'b1010: state_d = L0;
          4'b1011: state_d = S0;
          4'b1111: state_d = HALT;
          default: state_d = F0;
        endcase
      end
      ALU: begin
        ALUon   = 1'b1;
        ldFlag  = 1'b1;
        state_d = WB;
      end
      WB: begin
        ALUon   = 1'b1;
        ldReg   = 1'b1;
        state_d = F0;
      end
      BR: begin
        Tlabel  = 1'b1;
        ldPC    = bus.cc;
        state_d = F0;
      end
      L0: begin
        ldMAR   = 1'b1;
        state_d = L1;
      end
      L1: begin
        memRd = 1'b1;
        if (bus.mem_ready)  state_d = L2;
        else if (waitExpired) state_d = ERR;
        else waitCnt_d = waitCnt_q + 1'b1;
      end
      L2: begin
        ldReg   = 1'b1;
        state_d = F0;
      end
      S0: begin
        ldMAR   = 1'b1;
        state_d = S1;
      end
      S1: begin
        mm    = 1'b1;
        memWr = 1'b1;
        if (bus.mem_ready)  state_d = F0;
        else if (waitExpired) state_d = ERR;
        else waitCnt_d = waitCnt_q + 1'b1;
      end
      HALT: halted = 1'b1;
      ERR:  err    = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ldMAR    = ldMAR;
  assign bus.ldIR     = ldIR;
  assign bus.Tlabel   = Tlabel;
  assign bus.ALUon    = ALUon;
  assign bus.fnSelect = fnSelect;
  assign bus.mm       = mm;
  assign bus.ldFlag   = ldFlag;
  assign bus.ldPC     = ldPC;
  assign bus.incPC    = incPC;
  assign bus.ldReg    = ldReg;
  assign bus.mem_rd   = memRd;
  assign bus.mem_wr   = memWr;
  assign bus.halted   = halted;
  assign bus.err      = err;
  assign bus.state    = state_q;

endmodule
